// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears a single-port RAM after reset, then round-robin arbitrates two requesters onto it
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic last_b, rv_a, rv_b;
    // state, sweep counter, last grant and one-cycle read-response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            cnt    <= '0;
            last_b <= 1'b1;
            rv_a   <= 1'b0;
            rv_b   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= state == INIT ? cnt + 1'b1 : '0;
            if (a_ready || b_ready) last_b <= b_ready;
            rv_a  <= a_ready && !a_we;
            rv_b  <= b_ready && !b_we;
        end
    end
    // next state, grant decision and RAM port mux
    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        if (state == INIT) begin
            ram_we     = 1'b1;
            ram_addr   = cnt;
            state_next = cnt == '1 ? RUN : INIT;
        end else begin
            a_ready  = a_valid && (!b_valid || last_b);
            b_ready  = b_valid && !a_ready;
            ram_we   = a_ready ? a_we : b_ready ? b_we : 1'b0;
            ram_addr = a_ready ? a_addr : b_ready ? b_addr : '0;
            ram_din  = a_ready ? a_wdata : b_ready ? b_wdata : '0;
        end
    end
    // a reset cycle suppresses any response still in flight
    assign a_rvalid  = rv_a && !rst;
    assign b_rvalid  = rv_b && !rst;
    assign a_rdata   = a_rvalid ? ram_dout : '0;
    assign b_rdata   = b_rvalid ? ram_dout : '0;
    assign init_done = state == RUN;
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports a_valid/b_valid  input  1  requester A/B access request.
REQ-006 SHALL have ports a_ready/b_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr/b_addr  input  ADDR_WIDTH  access address.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports a_rvalid/b_rvalid  output  1  read data valid for A/B.
REQ-011 SHALL have ports a_rdata/b_rdata  output  DATA_WIDTH  read data.
REQ-012 SHALL have ports ram_we  output  1, ram_addr  output  ADDR_WIDTH, ram_din  output  DATA_WIDTH: drive the single-port RAM.
REQ-013 SHALL have port ram_dout  input  DATA_WIDTH  RAM registered read data (valid one cycle after address; read-during-write returns old data).
REQ-014 SHALL have port init_done  output  1  high once RAM clear sweep is complete.

Function
REQ-015 SHALL implement a two-state FSM: INIT (clear sweep) and RUN (arbitrated service).
REQ-016 In INIT SHALL drive ram_we=1, ram_addr=init counter, ram_din=0, a_ready=b_ready=0; counter increments by 1 each cycle from 0.
REQ-017 When INIT counter = depth-1, SHALL write that address, then enter RUN next cycle with init_done=1; INIT lasts exactly depth cycles.
REQ-018 In RUN SHALL grant at most one requester per cycle; a_ready/b_ready combinational from valids and priority, never both 1.
REQ-019 Single valid requester SHALL be granted in the same cycle (ready=valid).
REQ-020 Both valid SHALL grant the requester not granted last (round-robin); last-grant register updates only on a grant.
REQ-021 Granted request SHALL drive ram_we=we, ram_addr=addr, ram_din=wdata combinationally in the accept cycle.
REQ-022 No grant in RUN SHALL drive ram_we=0, ram_addr=0, ram_din=0.
REQ-023 Accepted read SHALL assert the owner's rvalid for exactly one cycle, the cycle after acceptance, with rdata=ram_dout.
REQ-024 Accepted writes SHALL produce no rvalid.
REQ-025 a_rdata/b_rdata SHALL be 0 whenever the matching rvalid is 0.
REQ-026 Back-to-back reads (any requester mix) SHALL sustain one access per cycle; rvalid pulses follow grant order.
REQ-027 Read accepted at same address as write in the previous cycle SHALL return the new data; RAM old-data-on-collision applies only within one access, which cannot occur (single grant).
REQ-028 Requesters holding valid without ready SHALL not be dropped; arbiter holds no request state beyond last-grant.

Reset
REQ-029 rst=1 at a clock edge SHALL set state=INIT, init counter=0, init_done=0, a_rvalid=b_rvalid=0, last-grant=B (A wins first tie).
REQ-030 rst during RUN SHALL discard any pending read response (no rvalid next cycle) and restart the full sweep from address 0.
REQ-031 rst during INIT SHALL restart the sweep from address 0.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-032 Release reset -> ram_we=1 for 16 cycles with ram_addr 0..15, ram_din=0; init_done=1 on cycle 17; readys 0 throughout INIT.
REQ-033 After init, A writes 0x5A to 0x3 then reads 0x3 -> a_ready=1 both cycles; a_rvalid=1 with a_rdata=0x5A cycle after read; b_rvalid stays 0.
REQ-034 A and B both hold read valid for 4 cycles after reset -> grants A,B,A,B; rvalids alternate A,B,A,B one cycle later.
REQ-035 B reads unwritten address 0x9 after init -> b_rdata=0x00 with b_rvalid one cycle after grant.
REQ-036 Assert rst in the cycle after an accepted read -> no rvalid, init_done=0, ram_addr restarts at 0.
